// File: rtl/pot_scan_if.sv
// SPI link between pot_scan (master) and the ADC128S-style converter (slave).
interface pot_scan_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/pot_scan.sv
// Round-robin SPI scanner for an 8-input 12-bit ADC feeding the band slide pots.
// Optional macro POT_SMOOTH_EN: quarter-step smoothing on each slot write instead of raw load.
module pot_scan #(
    parameter int unsigned NUM_POTS = 7,
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned GAP      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_en,
    pot_scan_if.master             spi,
    output logic [NUM_POTS*12-1:0] pots,
    output logic                   pot_vld,
    output logic [2:0]             pot_ch
);
    localparam int unsigned H    = SCLK_DIV / 2;
    localparam int unsigned CMAX = (SCLK_DIV > GAP) ? SCLK_DIV : GAP;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam logic [CW-1:0] H_M1   = CW'(H - 1);
    localparam logic [CW-1:0] H_C    = CW'(H);
    localparam logic [CW-1:0] DIV_M1 = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
    localparam logic [2:0]    LAST_CH = 3'(NUM_POTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FRONT, S_SHIFT, S_BACK, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            ss_n_q, ss_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [15:0]     tx_w;

    logic [2:0]      ch_q, prev_q, vch_q;
    logic            prime_q, vld_q;
    logic [11:0]     rx_q;
    logic [11:0]     slot_q [NUM_POTS];
    logic [11:0]     wr_val;
    logic            samp, wr_en, start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (scan_en) state_d = S_FRONT;
            end
            S_FRONT: if (cnt_q == H_M1) begin
                state_d = S_SHIFT;
                cnt_d   = '0;
                bit_d   = '0;
            end
            S_SHIFT: if (cnt_q == DIV_M1) begin
                cnt_d = '0;
                if (bit_q == 4'd15) state_d = S_BACK;
                else                bit_d   = bit_q + 4'd1;
            end
            S_BACK: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: if (cnt_q == GAP_M1) begin
                cnt_d   = '0;
                state_d = scan_en ? S_FRONT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        mosi_d = 1'b0;
        tx_w   = {2'b00, ch_q, 11'b0};
        case (state_d)
            S_FRONT: begin
                ss_n_d = 1'b0;
                mosi_d = tx_w[15];
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                sclk_d = (cnt_d >= H_C);
                mosi_d = tx_w[4'd15 - bit_d];
            end
            S_BACK:  ss_n_d = 1'b0;
            default: ;
        endcase
    end

    assign spi.SS_n = ss_n_q;
    assign spi.SCLK = sclk_q;
    assign spi.MOSI = mosi_q;

    assign samp  = (state_q == S_SHIFT) && (cnt_q == H_M1);
    assign wr_en = (state_q == S_BACK) && !prime_q;
    assign start = (state_q == S_IDLE) && scan_en;

`ifdef POT_SMOOTH_EN
    logic [NUM_POTS-1:0] first_q;
    logic [11:0]         old_w;
    logic                first_w;
    logic signed [13:0]  diff_w, acc_w;

    always_comb begin
        old_w   = '0;
        first_w = 1'b0;
        for (int unsigned i = 0; i < NUM_POTS; i++) begin
            if (prev_q == 3'(i)) begin
                old_w   = slot_q[i];
                first_w = first_q[i];
            end
        end
        diff_w = $signed({2'b00, rx_q}) - $signed({2'b00, old_w});
        acc_w  = $signed({2'b00, old_w}) + (diff_w >>> 2);
        if (first_w)                wr_val = rx_q;
        else if (acc_w < 14'sd0)    wr_val = '0;
        else if (acc_w > 14'sd4095) wr_val = '1;
        else                        wr_val = acc_w[11:0];
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            first_q <= '1;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_POTS; i++) begin
                if (prev_q == 3'(i)) first_q[i] <= 1'b0;
            end
        end
    end
`else
    assign wr_val = rx_q;
`endif

    // Only the last 12 of the 16 samples survive the shift, dropping rx[15:12].
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q    <= '0;
            prev_q  <= '0;
            vch_q   <= '0;
            prime_q <= 1'b1;
            vld_q   <= 1'b0;
            rx_q    <= '0;
            for (int unsigned i = 0; i < NUM_POTS; i++) slot_q[i] <= '0;
        end else begin
            vld_q <= wr_en;
            if (samp)  rx_q    <= {rx_q[10:0], spi.MISO};
            if (start) prime_q <= 1'b1;
            if (state_q == S_BACK) begin
                ch_q    <= (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;
                prev_q  <= ch_q;
                prime_q <= 1'b0;
            end
            if (wr_en) begin
                vch_q <= prev_q;
                for (int unsigned i = 0; i < NUM_POTS; i++) begin
                    if (prev_q == 3'(i)) slot_q[i] <= wr_val;
                end
            end
        end
    end

    always_comb begin
        pots = '0;
        for (int unsigned i = 0; i < NUM_POTS; i++) pots[i*12 +: 12] = slot_q[i];
    end

    assign pot_vld = vld_q;
    assign pot_ch  = vch_q;
endmodule

// File: tb/tb_pot_scan.sv
// Directed bench for pot_scan with a behavioural ADC that answers the previously addressed channel.
module tb_pot_scan;
    localparam int unsigned NP  = 7;
    localparam int unsigned DIV = 4;
    localparam int unsigned GP  = 8;

`ifdef POT_SMOOTH_EN
    localparam logic [11:0] E_TOPNIB = 12'h36F;
    localparam logic [11:0] E_S2     = 12'h14A;
    localparam logic [11:0] E_SM1    = 12'h500;
    localparam logic [11:0] E_SM2    = 12'h5C0;
`else
    localparam logic [11:0] E_TOPNIB = 12'hABC;
    localparam logic [11:0] E_S2     = 12'h222;
    localparam logic [11:0] E_SM1    = 12'h800;
    localparam logic [11:0] E_SM2    = 12'h800;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_en;
    logic [NP*12-1:0]  pots;
    logic              pot_vld;
    logic [2:0]        pot_ch;

    pot_scan_if spi_if();

    pot_scan #(.NUM_POTS(NP), .SCLK_DIV(DIV), .GAP(GP)) dut (
        .clk     (clk),
        .rst     (rst),
        .scan_en (scan_en),
        .spi     (spi_if),
        .pots    (pots),
        .pot_vld (pot_vld),
        .pot_ch  (pot_ch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          frames = 0, low_cnt = 0, rises = 0, bitk = 0, hi_cnt = 0, last_gap = 0;
    int          vld_cnt = 0, vld_bad = 0;
    int          low_hist [64];
    int          rise_hist [64];
    logic [15:0] mosi_hist [64];
    logic [15:0] mosi_w = '0, resp = '0;
    logic [2:0]  adc_ch = '0, last_vld_ch = '0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b1;
    int          ovr_frame = -1;
    logic [15:0] ovr_word = '0;
    logic        const_en = 1'b0;
    logic [11:0] const_val = '0;

    // ADC model and frame recorder, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (pot_vld === 1'b1) begin
            vld_cnt++;
            last_vld_ch = pot_ch;
            if (!(spi_if.SS_n === 1'b1 && ss_prev === 1'b0)) vld_bad++;
        end
        if (spi_if.SS_n === 1'b0) begin
            if (ss_prev === 1'b1) begin
                last_gap = hi_cnt;
                low_cnt  = 0;
                rises    = 0;
                bitk     = 0;
                mosi_w   = '0;
                if (ovr_frame == frames + 1) resp = ovr_word;
                else if (const_en)           resp = {4'h0, const_val};
                else                         resp = {4'h0, 12'h100 + {9'd0, adc_ch}};
            end
            low_cnt++;
            if (spi_if.SCLK === 1'b1 && sclk_prev === 1'b0) begin
                rises++;
                mosi_w = {mosi_w[14:0], spi_if.MOSI};
            end
            if (spi_if.SCLK === 1'b0 && sclk_prev === 1'b1 && bitk < 16) begin
                spi_if.MISO = resp[15 - bitk];
                bitk++;
            end
        end else begin
            spi_if.MISO = 1'b0;
            if (ss_prev === 1'b0) begin
                frames++;
                mosi_hist[frames % 64] = mosi_w;
                low_hist[frames % 64]  = low_cnt;
                rise_hist[frames % 64] = rises;
                adc_ch = mosi_w[13:11];
                hi_cnt = 0;
            end
            hi_cnt++;
        end
        ss_prev   = spi_if.SS_n;
        sclk_prev = spi_if.SCLK;
    end

    function automatic logic [11:0] slot(input int n);
        return pots[n*12 +: 12];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames < target && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        assert (frames >= target) else begin
            n_bad++;
            $error("FAIL wait_frame%0d: observed %0d frames expected %0d", target, frames, target);
        end
    endtask

    task automatic wait_shift(input int min_rises);
        int t = 0;
        while (!(spi_if.SS_n === 1'b0 && ss_prev === 1'b0 && rises >= min_rises) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        assert (t < 500) else begin
            n_bad++;
            $error("FAIL wait_shift: observed timeout %0d expected <500", t);
        end
    endtask

    initial begin
        int base;
        rst     = 1'b1;
        scan_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ssn",  32'(spi_if.SS_n), 32'd1);
            chk("rst_sclk", 32'(spi_if.SCLK), 32'd1);
            chk("rst_mosi", 32'(spi_if.MOSI), 32'd0);
            chk("rst_pots", 32'(pots === '0), 32'd1);
            chk("rst_vld",  32'(pot_vld), 32'd0);
            chk("rst_ch",   32'(pot_ch), 32'd0);
        end
        rst = 1'b0;

        wait_frames(1);
        chk("f1_low",   32'(low_hist[1]), 32'd67);
        chk("f1_sclk",  32'(rise_hist[1]), 32'd16);
        chk("f1_mosi",  32'(mosi_hist[1]), 32'h0000);
        chk("f1_novld", 32'(vld_cnt), 32'd0);

        wait_frames(2);
        chk("f2_mosi",  32'(mosi_hist[2]), 32'h0800);
        chk("f2_gap",   32'(last_gap), 32'd8);
        chk("f2_vld",   32'(vld_cnt), 32'd1);
        chk("f2_ch",    32'(last_vld_ch), 32'd0);
        chk("f2_slot0", 32'(slot(0)), 32'h100);

        wait_frames(8);
        chk("f7_mosi",  32'(mosi_hist[7]), 32'h3000);
        chk("f8_mosi",  32'(mosi_hist[8]), 32'h0000);
        chk("f8_low",   32'(low_hist[8]), 32'd67);
        chk("f8_vld",   32'(vld_cnt), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("f8_slot%0d", i), 32'(slot(i)), 32'h100 + 32'(i));

        ovr_word  = 16'hFABC;
        ovr_frame = 9;
        wait_frames(9);
        chk("topnib_ch",   32'(last_vld_ch), 32'd0);
        chk("topnib_slot", 32'(slot(0)), 32'(E_TOPNIB));

        wait_frames(10);
        ovr_word  = 16'h0222;
        ovr_frame = 11;
        wait_shift(4);
        scan_en = 1'b0;
        wait_frames(11);
        chk("drop_mosi", 32'(mosi_hist[11]), 32'h1800);
        chk("drop_ch",   32'(last_vld_ch), 32'd2);
        chk("drop_slot", 32'(slot(2)), 32'(E_S2));
        repeat (200) @(posedge clk);
        #1;
        chk("idle_frames", 32'(frames), 32'd11);
        chk("idle_ssn",    32'(spi_if.SS_n), 32'd1);
        chk("idle_sclk",   32'(spi_if.SCLK), 32'd1);
        chk("idle_vld",    32'(vld_cnt), 32'd10);

        scan_en = 1'b1;
        wait_frames(12);
        chk("re_mosi",  32'(mosi_hist[12]), 32'h2000);
        chk("re_prime", 32'(vld_cnt), 32'd10);
        wait_frames(13);
        chk("re2_mosi", 32'(mosi_hist[13]), 32'h2800);
        chk("re2_ch",   32'(last_vld_ch), 32'd4);
        chk("re2_vld",  32'(vld_cnt), 32'd11);
        chk("re2_slot", 32'(slot(4)), 32'h104);

        wait_shift(5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ssn",  32'(spi_if.SS_n), 32'd1);
        chk("mrst_vld",  32'(pot_vld), 32'd0);
        chk("mrst_pots", 32'(pots === '0), 32'd1);
        @(posedge clk); #1;
        chk("mrst_cnt",  32'(vld_cnt), 32'd11);
        const_en  = 1'b1;
        const_val = 12'h400;
        rst  = 1'b0;
        base = frames;

        wait_frames(base + 1);
        chk("sm_mosi",  32'(mosi_hist[(base + 1) % 64]), 32'h0000);
        chk("sm_prime", 32'(vld_cnt), 32'd11);
        wait_frames(base + 2);
        chk("sm_load",  32'(slot(0)), 32'h400);
        chk("sm_vld",   32'(vld_cnt), 32'd12);
        const_val = 12'h800;
        wait_frames(base + 9);
        chk("sm_step1", 32'(slot(0)), 32'(E_SM1));
        wait_frames(base + 16);
        chk("sm_step2", 32'(slot(0)), 32'(E_SM2));

        chk("vld_only_at_rise", 32'(vld_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
